// File: rtl/axi_sram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_sram_slave_if
// Purpose : Bus types and the AXI bundle between a master and axi_sram_slave.
//           The package holds the request/response structs and the two FSM
//           state types. The interface carries the structs, the ID vectors and
//           the slave's FSM state for observation.
// Ports (interface members):
//   axi_req                    master -> slave  AR/AW/W channels, rready, bready
//   axi_req_arid/awid/wid      master -> slave  request IDs (BUS_WIDTH)
//   axi_resp                   slave  -> master ready/valid/data/resp fields
//   axi_resp_rid/bid           slave  -> master response IDs (BUS_WIDTH)
//   dbg_r_state/dbg_w_state    slave  -> master current read/write FSM state
// Handshake rule used on every channel: a transfer happens on a rising clk
// edge where both valid and ready are 1. A source holds valid and its payload
// stable until that edge. Ready may depend on state but never on valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package axi_sram_pkg;

    typedef struct packed {
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        rready;
        logic        bready;
    } axi_req_t;

    typedef struct packed {
        logic        arready;
        logic        awready;
        logic        wready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
        logic [1:0]  rresp;
        logic        bvalid;
        logic [1:0]  bresp;
    } axi_resp_t;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_BURST = 1'b1
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

endpackage

interface axi_sram_slave_if #(
    parameter int BUS_WIDTH = 4
);
    import axi_sram_pkg::*;

    axi_req_t               axi_req;
    logic [BUS_WIDTH-1:0]   axi_req_arid;
    logic [BUS_WIDTH-1:0]   axi_req_awid;
    logic [BUS_WIDTH-1:0]   axi_req_wid;
    axi_resp_t              axi_resp;
    logic [BUS_WIDTH-1:0]   axi_resp_rid;
    logic [BUS_WIDTH-1:0]   axi_resp_bid;
    r_state_t               dbg_r_state;
    w_state_t               dbg_w_state;

    modport master (
        output axi_req, axi_req_arid, axi_req_awid, axi_req_wid,
        input  axi_resp, axi_resp_rid, axi_resp_bid, dbg_r_state, dbg_w_state
    );

    modport slave (
        input  axi_req, axi_req_arid, axi_req_awid, axi_req_wid,
        output axi_resp, axi_resp_rid, axi_resp_bid, dbg_r_state, dbg_w_state
    );

endinterface

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// Purpose : AXI slave in front of a MEM_WORDS x 32-bit storage array. Every
//           burst is INCR of 4-byte beats (size/burst fields ignored, beat
//           count = len+1). Read and write paths are independent FSMs that
//           may run concurrently.
// Parameters:
//   BUS_WIDTH  AXI ID width in bits
//   MEM_WORDS  number of 32-bit words (power of two)
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset (storage contents are kept)
//   axi        axi_sram_slave_if.slave: axi_req, axi_req_arid/awid/wid,
//              axi_resp, axi_resp_rid/bid, dbg_r_state/dbg_w_state
// Optional build macro:
//   AXI_SLAVE_RESP_CHECK_EN  bursts running past the last word answer SLVERR
//                            (reads return 0, writes are dropped), and a
//                            misplaced/missing wlast gives bresp SLVERR.
//                            Undefined: always OKAY, word index wraps.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int BUS_WIDTH = 4,
    parameter int MEM_WORDS = 1024
) (
    input logic              clk,
    input logic              rst_n,
    axi_sram_slave_if.slave  axi
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Storage: no reset, survives rst_n.
    logic [31:0] r_mem [MEM_WORDS];

    // ---------------------------------------------------------------- read side
    r_state_t               r_rd_state;
    r_state_t               w_rd_state_nxt;
    logic [IDX_W-1:0]       r_rd_idx;
    logic [7:0]             r_rd_len;
    logic [7:0]             r_rd_beat;
    logic [BUS_WIDTH-1:0]   r_rd_id;

    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_rd_last;
    logic [IDX_W-1:0]       w_ar_idx;
    logic                   w_rd_err;

    // --------------------------------------------------------------- write side
    w_state_t               r_wr_state;
    w_state_t               w_wr_state_nxt;
    logic [IDX_W-1:0]       r_wr_idx;
    logic [7:0]             r_wr_len;
    logic [7:0]             r_wr_beat;
    logic [BUS_WIDTH-1:0]   r_wr_id;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_wr_last;
    logic [IDX_W-1:0]       w_aw_idx;
    logic                   w_wr_drop;
    logic                   w_wr_bad;

    axi_resp_t              w_resp;

    assign w_ar_idx  = axi.axi_req.araddr[IDX_W+1:2];
    assign w_aw_idx  = axi.axi_req.awaddr[IDX_W+1:2];

    assign w_ar_hs   = axi.axi_req.arvalid && (r_rd_state == R_IDLE);
    assign w_r_hs    = (r_rd_state == R_BURST) && axi.axi_req.rready;
    assign w_rd_last = (r_rd_beat == r_rd_len);

    assign w_aw_hs   = axi.axi_req.awvalid && (r_wr_state == W_IDLE);
    assign w_w_hs    = axi.axi_req.wvalid && (r_wr_state == W_DATA);
    assign w_b_hs    = axi.axi_req.bready && (r_wr_state == W_RESP);
    assign w_wr_last = (r_wr_beat == r_wr_len);

`ifdef AXI_SLAVE_RESP_CHECK_EN
    // Error flags are decided once per burst at address acceptance, except
    // the wlast flag which accumulates over the data beats.
    logic                   r_rd_err;
    logic                   r_wr_err;
    logic                   r_wlast_err;
    logic [IDX_W+8:0]       w_ar_end;
    logic [IDX_W+8:0]       w_aw_end;
    logic                   w_unused;

    assign w_ar_end = {9'd0, w_ar_idx} + {{(IDX_W+1){1'b0}}, axi.axi_req.arlen};
    assign w_aw_end = {9'd0, w_aw_idx} + {{(IDX_W+1){1'b0}}, axi.axi_req.awlen};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_err    <= 1'b0;
            r_wr_err    <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_rd_err <= (w_ar_end >= (IDX_W+9)'(MEM_WORDS));
            end
            if (w_aw_hs) begin
                r_wr_err    <= (w_aw_end >= (IDX_W+9)'(MEM_WORDS));
                r_wlast_err <= 1'b0;
            end else if (w_w_hs && (axi.axi_req.wlast != w_wr_last)) begin
                r_wlast_err <= 1'b1;
            end
        end
    end

    assign w_rd_err  = r_rd_err;
    assign w_wr_drop = r_wr_err;
    assign w_wr_bad  = r_wr_err || r_wlast_err;
    assign w_unused  = ^{axi.axi_req.araddr, axi.axi_req.awaddr,
                         axi.axi_req.arsize, axi.axi_req.arburst,
                         axi.axi_req.awsize, axi.axi_req.awburst,
                         axi.axi_req_wid};
`else
    logic w_unused;

    assign w_rd_err  = 1'b0;
    assign w_wr_drop = 1'b0;
    assign w_wr_bad  = 1'b0;
    // wlast is not needed: the write burst ends on the awlen beat count.
    assign w_unused  = ^{axi.axi_req.araddr, axi.axi_req.awaddr,
                         axi.axi_req.arsize, axi.axi_req.arburst,
                         axi.axi_req.awsize, axi.axi_req.awburst,
                         axi.axi_req.wlast, axi.axi_req_wid};
`endif

    // ------------------------------------------------------------ read FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_rd_idx   <= '0;
            r_rd_len   <= '0;
            r_rd_beat  <= '0;
            r_rd_id    <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_ar_hs) begin
                r_rd_idx  <= w_ar_idx;
                r_rd_len  <= axi.axi_req.arlen;
                r_rd_id   <= axi.axi_req_arid;
                r_rd_beat <= '0;
            end else if (w_r_hs) begin
                // Index wraps naturally at MEM_WORDS.
                r_rd_idx  <= r_rd_idx + 1'b1;
                r_rd_beat <= r_rd_beat + 8'd1;
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_BURST;
            R_BURST: if (w_r_hs && w_rd_last) w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------ write FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_wr_idx   <= '0;
            r_wr_len   <= '0;
            r_wr_beat  <= '0;
            r_wr_id    <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_aw_hs) begin
                r_wr_idx  <= w_aw_idx;
                r_wr_len  <= axi.axi_req.awlen;
                r_wr_id   <= axi.axi_req_awid;
                r_wr_beat <= '0;
            end else if (w_w_hs) begin
                r_wr_idx  <= r_wr_idx + 1'b1;
                r_wr_beat <= r_wr_beat + 8'd1;
            end
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wr_last) w_wr_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Storage write port. Gated by the write FSM state, which the async
    // reset forces to W_IDLE, so an abandoned burst writes nothing more.
    always_ff @(posedge clk) begin
        if (w_w_hs && !w_wr_drop) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.axi_req.wstrb[b]) begin
                    r_mem[r_wr_idx][8*b +: 8] <= axi.axi_req.wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------ outputs
    // rdata is a combinational read of the current word: a write landing on
    // the same edge becomes visible the cycle after it.
    always_comb begin
        w_resp         = '0;
        w_resp.arready = (r_rd_state == R_IDLE);
        w_resp.awready = (r_wr_state == W_IDLE);
        w_resp.wready  = (r_wr_state == W_DATA);
        if (r_rd_state == R_BURST) begin
            w_resp.rvalid = 1'b1;
            w_resp.rdata  = w_rd_err ? 32'd0 : r_mem[r_rd_idx];
            w_resp.rlast  = w_rd_last;
            w_resp.rresp  = w_rd_err ? 2'b10 : 2'b00;
        end
        if (r_wr_state == W_RESP) begin
            w_resp.bvalid = 1'b1;
            w_resp.bresp  = w_wr_bad ? 2'b10 : 2'b00;
        end
    end

    assign axi.axi_resp     = w_resp;
    assign axi.axi_resp_rid = r_rd_id;
    assign axi.axi_resp_bid = r_wr_id;
    assign axi.dbg_r_state  = r_rd_state;
    assign axi.dbg_w_state  = r_wr_state;

endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps

module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  localparam int BW = 4;
  localparam int MW = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wdata_q[$];
  logic [3:0]  wstrb_q[$];

  axi_sram_slave_if #(.BUS_WIDTH(BW)) bus();

  axi_sram_slave #(.BUS_WIDTH(BW), .MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi   (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.axi_req = '0;
    bus.axi_req_arid = '0;
    bus.axi_req_awid = '0;
    bus.axi_req_wid = '0;
  endtask

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // driver tasks: inputs change #1 after posedge, outputs sampled on negedge
  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    bit hs = 0;
    int guard = 0;
    bus.axi_req.araddr = addr;
    bus.axi_req.arlen = len;
    bus.axi_req.arsize = 3'd2;
    bus.axi_req.arburst = 2'b01;
    bus.axi_req_arid = id;
    bus.axi_req.arvalid = 1'b1;
    while (!hs && guard < 50) begin
      @(negedge clk);
      hs = bus.axi_resp.arready;
      @(posedge clk); #1;
      guard++;
    end
    bus.axi_req.arvalid = 1'b0;
    check("ar_accept", {31'd0, hs}, 32'd1);
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    bit hs = 0;
    int guard = 0;
    bus.axi_req.awaddr = addr;
    bus.axi_req.awlen = len;
    bus.axi_req.awsize = 3'd2;
    bus.axi_req.awburst = 2'b01;
    bus.axi_req_awid = id;
    bus.axi_req.awvalid = 1'b1;
    while (!hs && guard < 50) begin
      @(negedge clk);
      hs = bus.axi_resp.awready;
      @(posedge clk); #1;
      guard++;
    end
    bus.axi_req.awvalid = 1'b0;
    check("aw_accept", {31'd0, hs}, 32'd1);
  endtask

  // Sends n_beats beats from wdata_q/wstrb_q, wlast on beat len.
  task automatic w_send(input int n_beats, input int len);
    for (int i = 0; i < n_beats; i++) begin
      bit hs = 0;
      int guard = 0;
      bus.axi_req.wdata = wdata_q.pop_front();
      bus.axi_req.wstrb = wstrb_q.pop_front();
      bus.axi_req.wlast = (i == len);
      bus.axi_req.wvalid = 1'b1;
      while (!hs && guard < 50) begin
        @(negedge clk);
        hs = bus.axi_resp.wready;
        @(posedge clk); #1;
        guard++;
      end
      check("w_accept", {31'd0, hs}, 32'd1);
    end
    bus.axi_req.wvalid = 1'b0;
    bus.axi_req.wlast = 1'b0;
  endtask

  task automatic b_wait(input logic [3:0] id, input logic [1:0] resp);
    bit got = 0;
    int guard = 0;
    bus.axi_req.bready = 1'b1;
    while (!got && guard < 50) begin
      @(negedge clk);
      if (bus.axi_resp.bvalid) begin
        got = 1;
        check("bid", {28'd0, bus.axi_resp_bid}, {28'd0, id});
        check("bresp", {30'd0, bus.axi_resp.bresp}, {30'd0, resp});
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.axi_req.bready = 1'b0;
    check("b_seen", {31'd0, got}, 32'd1);
  endtask

  // scoreboard side of the R channel: pops exp_q per accepted beat
  task automatic r_collect(input int len, input logic [3:0] id, input bit toggle,
                           input logic [1:0] resp);
    int beat = 0;
    int guard = 0;
    bit rr = 1;
    bit pend = 0;
    logic [31:0] exp;
    while (beat <= len && guard < 200) begin
      bus.axi_req.rready = rr;
      @(negedge clk);
      if (pend) check("rvalid_held", {31'd0, bus.axi_resp.rvalid}, 32'd1);
      exp = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
      if (bus.axi_resp.rvalid) begin
        check("rdata", bus.axi_resp.rdata, exp);
        check("rlast", {31'd0, bus.axi_resp.rlast}, {31'd0, (beat == len)});
        if (rr) begin
          check("rid", {28'd0, bus.axi_resp_rid}, {28'd0, id});
          check("rresp", {30'd0, bus.axi_resp.rresp}, {30'd0, resp});
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beat++;
          pend = 0;
        end else begin
          pend = 1;
        end
      end
      @(posedge clk); #1;
      guard++;
      if (toggle) rr = !rr;
    end
    bus.axi_req.rready = 1'b0;
    check("r_beats", beat, len + 1);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                    input logic [1:0] resp);
    aw_send(addr, len, id);
    w_send(int'(len) + 1, int'(len));
    b_wait(id, resp);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                    input bit toggle, input logic [1:0] resp);
    ar_send(addr, len, id);
    r_collect(int'(len), id, toggle, resp);
  endtask

  task automatic push_w(input logic [31:0] d, input logic [3:0] s);
    wdata_q.push_back(d);
    wstrb_q.push_back(s);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    check("rst_arready", {31'd0, bus.axi_resp.arready}, 32'd1);
    check("rst_awready", {31'd0, bus.axi_resp.awready}, 32'd1);
    check("rst_wready", {31'd0, bus.axi_resp.wready}, 32'd0);
    check("rst_rvalid", {31'd0, bus.axi_resp.rvalid}, 32'd0);
    check("rst_rlast", {31'd0, bus.axi_resp.rlast}, 32'd0);
    check("rst_rdata", bus.axi_resp.rdata, 32'd0);
    check("rst_rresp", {30'd0, bus.axi_resp.rresp}, 32'd0);
    check("rst_bvalid", {31'd0, bus.axi_resp.bvalid}, 32'd0);
    check("rst_bresp", {30'd0, bus.axi_resp.bresp}, 32'd0);
    check("rst_rid", {28'd0, bus.axi_resp_rid}, 32'd0);
    check("rst_bid", {28'd0, bus.axi_resp_bid}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write / read
    push_w(32'hDEADBEEF, 4'hF);
    wr(32'h10, 8'd0, 4'd3, 2'b00);
    exp_q.push_back(32'hDEADBEEF);
    rd(32'h10, 8'd0, 4'd5, 1'b0, 2'b00);

    // byte strobes
    push_w(32'h11223344, 4'hF);
    wr(32'h20, 8'd0, 4'd1, 2'b00);
    push_w(32'hAABBCCDD, 4'b0101);
    wr(32'h20, 8'd0, 4'd1, 2'b00);
    exp_q.push_back(32'h11BB33DD);
    rd(32'h20, 8'd0, 4'd2, 1'b0, 2'b00);

    // burst with rready backpressure 1,0,1,0,...
    for (int i = 1; i <= 4; i++) push_w(i, 4'hF);
    wr(32'h0, 8'd3, 4'd4, 2'b00);
    for (int i = 1; i <= 4; i++) exp_q.push_back(i);
    rd(32'h0, 8'd3, 4'd6, 1'b1, 2'b00);

    // concurrent read of 0x40 and write of 0x80
    for (int i = 0; i < 4; i++) push_w(32'hC0DE0040 + i, 4'hF);
    wr(32'h40, 8'd3, 4'd1, 2'b00);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0DE0040 + i);
    for (int i = 0; i < 4; i++) push_w(32'h80000080 + i, 4'hF);
    fork
      begin
        ar_send(32'h40, 8'd3, 4'd7);
        r_collect(3, 4'd7, 1'b0, 2'b00);
      end
      begin
        aw_send(32'h80, 8'd3, 4'd9);
        w_send(4, 3);
        b_wait(4'd9, 2'b00);
      end
    join
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h80000080 + i);
    rd(32'h80, 8'd3, 4'd8, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hC0DE0040 + i);
    rd(32'h40, 8'd3, 4'd8, 1'b0, 2'b00);

    // reset in the middle of a write burst
    for (int i = 0; i < 4; i++) push_w(32'h000000A0 + i, 4'hF);
    wr(32'h100, 8'd3, 4'd2, 2'b00);
    for (int i = 0; i < 4; i++) push_w(32'h55550000 + i, 4'hF);
    aw_send(32'h100, 8'd3, 4'd4);
    w_send(1, 3);
    rst_n = 1'b0;
    #2;
    check("mid_arready", {31'd0, bus.axi_resp.arready}, 32'd1);
    check("mid_awready", {31'd0, bus.axi_resp.awready}, 32'd1);
    check("mid_wready", {31'd0, bus.axi_resp.wready}, 32'd0);
    check("mid_bvalid", {31'd0, bus.axi_resp.bvalid}, 32'd0);
    check("mid_wstate", {30'd0, bus.dbg_w_state}, {30'd0, W_IDLE});
    wdata_q.delete();
    wstrb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_bvalid", {31'd0, bus.axi_resp.bvalid}, 32'd0);
    exp_q.push_back(32'h55550000);
    for (int i = 1; i < 4; i++) exp_q.push_back(32'h000000A0 + i);
    rd(32'h100, 8'd3, 4'd3, 1'b0, 2'b00);
    push_w(32'h12345678, 4'hF);
    wr(32'h104, 8'd0, 4'd7, 2'b00);
    exp_q.push_back(32'h12345678);
    rd(32'h104, 8'd0, 4'd7, 1'b0, 2'b00);

    // burst crossing the top of memory
    push_w(32'h3FF00001, 4'hF);
    push_w(32'h00000A0A, 4'hF);
`ifdef AXI_SLAVE_RESP_CHECK_EN
    wr(32'hFFC, 8'd1, 4'd2, 2'b10);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    rd(32'hFFC, 8'd1, 4'd3, 1'b0, 2'b10);
    exp_q.push_back(32'd1);
    rd(32'h0, 8'd0, 4'd3, 1'b0, 2'b00);
`else
    wr(32'hFFC, 8'd1, 4'd2, 2'b00);
    exp_q.push_back(32'h3FF00001);
    exp_q.push_back(32'h00000A0A);
    rd(32'hFFC, 8'd1, 4'd3, 1'b0, 2'b00);
    exp_q.push_back(32'h00000A0A);
    rd(32'h0, 8'd0, 4'd3, 1'b0, 2'b00);
`endif

    check("exp_q_empty", exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    report();
    $finish;
  end

  // global time bound
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    report();
    $fatal(1, "watchdog expired");
  end

endmodule
